// File: rtl/irq_priority_controller_if.sv
// Interrupt controller bundle: peripheral lines, enable register access and
// the request/ack/eoi handshake with the control unit.
interface irq_priority_controller_if #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2,
  parameter int ADDR_W  = 32
);
  logic [NUM_SRC-1:0] irq_src;
  logic               irq_en_we;
  logic [NUM_SRC-1:0] irq_en_wdata;
  logic [NUM_SRC-1:0] irq_en;
  logic [NUM_SRC-1:0] irq_pending;
  logic               irq_req;
  logic               irq_ack;
  logic               irq_eoi;
  logic [ID_W-1:0]    irq_id;
  logic [ADDR_W-1:0]  irq_vector;
  logic               irq_active;

  modport master (
    output irq_src, irq_en_we, irq_en_wdata, irq_ack, irq_eoi,
    input  irq_en, irq_pending, irq_req, irq_id, irq_vector, irq_active
  );

  modport slave (
    input  irq_src, irq_en_we, irq_en_wdata, irq_ack, irq_eoi,
    output irq_en, irq_pending, irq_req, irq_id, irq_vector, irq_active
  );
endinterface

// File: rtl/irq_priority_controller.sv
// Fixed-priority interrupt controller: synchronises and edge-detects peripheral
// lines, latches pending requests and hands one at a time to the control unit.
module irq_priority_controller #(
  parameter int                NUM_SRC    = 4,
  parameter int                ID_W       = 2,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE   = 32'h0000_0100,
  parameter int unsigned       VEC_STRIDE = 8
) (
  input logic clock,
  input logic reset_n,
  irq_priority_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2
  } stateT;

  stateT              state;
  logic [NUM_SRC-1:0] sync1, sync2, sync3;
  logic [NUM_SRC-1:0] riseEdge, pending, enable, eligible, ackClear;
  logic [ID_W-1:0]    winnerId, curId;
  logic [ADDR_W-1:0]  winnerVec, curVec;
  logic               anyEligible, reqReg, activeReg;

  // Lowest eligible index wins; the loop runs high-to-low so the last hit sticks.
  always_comb begin
    riseEdge    = sync2 & ~sync3;
    eligible    = pending & enable;
    winnerId    = '0;
    anyEligible = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winnerId    = ID_W'(i);
        anyEligible = 1'b1;
      end
    end
    winnerVec = VEC_BASE + ADDR_W'(winnerId) * ADDR_W'(VEC_STRIDE);
    ackClear  = '0;
    if (state == REQ && bus.irq_ack) ackClear[curId] = 1'b1;
  end

  // Synchroniser chain, pending latch and enable register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= '0;
      sync2   <= '0;
      sync3   <= '0;
      pending <= '0;
      enable  <= '0;
    end else begin
      sync1   <= bus.irq_src;
      sync2   <= sync1;
      sync3   <= sync2;
      pending <= (pending & ~ackClear) | riseEdge;
      if (bus.irq_en_we) enable <= bus.irq_en_wdata;
    end
  end

  // Request FSM; id/vector are captured on leaving IDLE and frozen until the next arbitration.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      reqReg    <= 1'b0;
      activeReg <= 1'b0;
      curId     <= '0;
      curVec    <= VEC_BASE;
    end else begin
      case (state)
        IDLE: begin
          if (anyEligible) begin
            state  <= REQ;
            reqReg <= 1'b1;
            curId  <= winnerId;
            curVec <= winnerVec;
          end
        end
        REQ: begin
          if (bus.irq_ack) begin
            state     <= ACTIVE;
            reqReg    <= 1'b0;
            activeReg <= 1'b1;
          end else if (!eligible[curId]) begin
            state  <= IDLE;
            reqReg <= 1'b0;
          end
        end
        ACTIVE: begin
          if (bus.irq_eoi) begin
            state     <= IDLE;
            activeReg <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          reqReg    <= 1'b0;
          activeReg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.irq_en      = enable;
  assign bus.irq_pending = pending;
  assign bus.irq_req     = reqReg;
  assign bus.irq_active  = activeReg;
  assign bus.irq_id      = curId;
  assign bus.irq_vector  = curVec;

endmodule
